fg_burst_packet_gen: RTL and testbench

FG_BURST_PACKET_GEN -- requirements
Module: fg_burst_packet_gen

---
 rtl/fg_burst_packet_gen.sv | 204 ++++++++++++++++++++
 tb/tb_fg_burst_packet_gen.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fg_burst_packet_gen.sv
// Burst packet generator: splits a descriptor burst into MTU-sized packets,
// each emitted as a header followed by an AXI-Stream payload with a selectable byte pattern.
module fg_burst_packet_gen #(
    parameter int DEST_WIDTH      = 8,
    parameter int DATA_WIDTH      = 64,
    parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter int LEN_WIDTH       = 16,
    parameter int BURST_LEN_WIDTH = 32,
    parameter int SEQ_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       input_bd_valid,
    output logic                       input_bd_ready,
    input  logic [DEST_WIDTH-1:0]      input_bd_dest,
    input  logic [BURST_LEN_WIDTH-1:0] input_bd_burst_len,
    input  logic [1:0]                 input_bd_mode,

    output logic                       output_hdr_valid,
    input  logic                       output_hdr_ready,
    output logic [DEST_WIDTH-1:0]      output_hdr_dest,
    output logic [LEN_WIDTH-1:0]       output_hdr_len,
    output logic [SEQ_WIDTH-1:0]       output_hdr_seq,
    output logic                       output_hdr_last,

    output logic [DATA_WIDTH-1:0]      output_payload_tdata,
    output logic [KEEP_WIDTH-1:0]      output_payload_tkeep,
    output logic                       output_payload_tvalid,
    input  logic                       output_payload_tready,
    output logic                       output_payload_tlast,
    output logic                       output_payload_tuser,

    output logic                       busy,

    input  logic [LEN_WIDTH-1:0]       payload_mtu,
    input  logic [7:0]                 ipg_cycles
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HDR     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_GAP     = 2'd3;

    localparam int OFF_W = LEN_WIDTH + 1;

    logic [1:0]                 state;
    logic [DEST_WIDTH-1:0]      dest_r;
    logic [BURST_LEN_WIDTH-1:0] remaining;
    logic [1:0]                 mode_r;
    logic [LEN_WIDTH-1:0]       mtu_r;
    logic [7:0]                 ipg_r;
    logic [7:0]                 gap_cnt;
    logic [SEQ_WIDTH-1:0]       seq;
    logic [OFF_W-1:0]           off_r;

    logic                       bd_ready_r;
    logic                       hdr_valid_r;
    logic                       tvalid_r;
    logic                       tlast_r;
    logic [DATA_WIDTH-1:0]      tdata_r;
    logic [KEEP_WIDTH-1:0]      tkeep_r;

    logic [BURST_LEN_WIDTH-1:0] mtu_ext;
    logic                       cur_last;
    logic [LEN_WIDTH-1:0]       cur_len;
    logic [BURST_LEN_WIDTH-1:0] rem_after;

    logic [OFF_W-1:0]           beat_off;
    logic [OFF_W-1:0]           byte_idx;
    logic [DATA_WIDTH-1:0]      beat_data;
    logic [KEEP_WIDTH-1:0]      beat_keep;
    logic                       beat_last;

    // Packet length is derived from registered state only, so it stays stable through HDR and PAYLOAD.
    assign mtu_ext   = BURST_LEN_WIDTH'(mtu_r);
    assign cur_last  = (remaining <= mtu_ext);
    assign cur_len   = cur_last ? LEN_WIDTH'(remaining) : mtu_r;
    assign rem_after = remaining - BURST_LEN_WIDTH'(cur_len);

    assign beat_off  = (state == ST_HDR) ? '0 : off_r;

    always_comb begin
        beat_data = '0;
        beat_keep = '0;
        byte_idx  = '0;
        beat_last = ((beat_off + OFF_W'(KEEP_WIDTH)) >= OFF_W'(cur_len));
        for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
            byte_idx = beat_off + OFF_W'(i);
            if (byte_idx < OFF_W'(cur_len)) begin
                beat_keep[i] = 1'b1;
                case (mode_r)
                    2'd0:    beat_data[i*8 +: 8] = 8'(byte_idx);
                    2'd1:    beat_data[i*8 +: 8] = 8'h00;
                    2'd2:    beat_data[i*8 +: 8] = 8'(seq);
                    default: beat_data[i*8 +: 8] = 8'hFF;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            dest_r      <= '0;
            remaining   <= '0;
            mode_r      <= '0;
            mtu_r       <= '0;
            ipg_r       <= '0;
            gap_cnt     <= '0;
            seq         <= '0;
            off_r       <= '0;
            bd_ready_r  <= 1'b0;
            hdr_valid_r <= 1'b0;
            tvalid_r    <= 1'b0;
            tlast_r     <= 1'b0;
            tdata_r     <= '0;
            tkeep_r     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bd_ready_r <= 1'b1;
                    if (input_bd_valid && bd_ready_r) begin
                        dest_r    <= input_bd_dest;
                        remaining <= input_bd_burst_len;
                        mode_r    <= input_bd_mode;
                        mtu_r     <= (payload_mtu == '0) ? LEN_WIDTH'(1) : payload_mtu;
                        ipg_r     <= ipg_cycles;
                        if (input_bd_burst_len != '0) begin
                            state       <= ST_HDR;
                            hdr_valid_r <= 1'b1;
                            bd_ready_r  <= 1'b0;
                        end
                    end
                end
                ST_HDR: begin
                    if (output_hdr_ready) begin
                        state       <= ST_PAYLOAD;
                        hdr_valid_r <= 1'b0;
                        tvalid_r    <= 1'b1;
                        tdata_r     <= beat_data;
                        tkeep_r     <= beat_keep;
                        tlast_r     <= beat_last;
                        off_r       <= OFF_W'(KEEP_WIDTH);
                    end
                end
                ST_PAYLOAD: begin
                    if (output_payload_tready) begin
                        if (tlast_r) begin
                            tvalid_r  <= 1'b0;
                            tlast_r   <= 1'b0;
                            tdata_r   <= '0;
                            tkeep_r   <= '0;
                            remaining <= rem_after;
                            seq       <= seq + 1'b1;
                            if (ipg_r != '0) begin
                                state   <= ST_GAP;
                                gap_cnt <= ipg_r;
                            end else if (rem_after != '0) begin
                                state       <= ST_HDR;
                                hdr_valid_r <= 1'b1;
                            end else begin
                                state      <= ST_IDLE;
                                bd_ready_r <= 1'b1;
                            end
                        end else begin
                            tdata_r <= beat_data;
                            tkeep_r <= beat_keep;
                            tlast_r <= beat_last;
                            off_r   <= off_r + OFF_W'(KEEP_WIDTH);
                        end
                    end
                end
                default: begin
                    if (gap_cnt == 8'd1) begin
                        if (remaining != '0) begin
                            state       <= ST_HDR;
                            hdr_valid_r <= 1'b1;
                        end else begin
                            state      <= ST_IDLE;
                            bd_ready_r <= 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
            endcase
        end
    end

    assign input_bd_ready        = bd_ready_r;
    assign output_hdr_valid      = hdr_valid_r;
    assign output_hdr_dest       = dest_r;
    assign output_hdr_len        = cur_len;
    assign output_hdr_seq        = seq;
    assign output_hdr_last       = cur_last;
    assign output_payload_tdata  = tdata_r;
    assign output_payload_tkeep  = tkeep_r;
    assign output_payload_tvalid = tvalid_r;
    assign output_payload_tlast  = tlast_r;
    assign output_payload_tuser  = 1'b0;
    assign busy                  = (state != ST_IDLE);

endmodule

// File: tb/tb_fg_burst_packet_gen.sv
// Scoreboard bench for fg_burst_packet_gen: a reference model queues expected
// headers and beats per descriptor; a negedge monitor pops and compares them.
module tb_fg_burst_packet_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        input_bd_valid = 1'b0;
    logic        input_bd_ready;
    logic [7:0]  input_bd_dest = '0;
    logic [31:0] input_bd_burst_len = '0;
    logic [1:0]  input_bd_mode = '0;
    logic        output_hdr_valid;
    logic        output_hdr_ready = 1'b1;
    logic [7:0]  output_hdr_dest;
    logic [15:0] output_hdr_len;
    logic [15:0] output_hdr_seq;
    logic        output_hdr_last;
    logic [63:0] output_payload_tdata;
    logic [7:0]  output_payload_tkeep;
    logic        output_payload_tvalid;
    logic        output_payload_tready = 1'b1;
    logic        output_payload_tlast;
    logic        output_payload_tuser;
    logic        busy;
    logic [15:0] payload_mtu = '0;
    logic [7:0]  ipg_cycles = '0;

    fg_burst_packet_gen #(
        .DEST_WIDTH(8),
        .DATA_WIDTH(64),
        .KEEP_WIDTH(8),
        .LEN_WIDTH(16),
        .BURST_LEN_WIDTH(32),
        .SEQ_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .input_bd_valid(input_bd_valid),
        .input_bd_ready(input_bd_ready),
        .input_bd_dest(input_bd_dest),
        .input_bd_burst_len(input_bd_burst_len),
        .input_bd_mode(input_bd_mode),
        .output_hdr_valid(output_hdr_valid),
        .output_hdr_ready(output_hdr_ready),
        .output_hdr_dest(output_hdr_dest),
        .output_hdr_len(output_hdr_len),
        .output_hdr_seq(output_hdr_seq),
        .output_hdr_last(output_hdr_last),
        .output_payload_tdata(output_payload_tdata),
        .output_payload_tkeep(output_payload_tkeep),
        .output_payload_tvalid(output_payload_tvalid),
        .output_payload_tready(output_payload_tready),
        .output_payload_tlast(output_payload_tlast),
        .output_payload_tuser(output_payload_tuser),
        .busy(busy),
        .payload_mtu(payload_mtu),
        .ipg_cycles(ipg_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  dest;
        logic [15:0] len;
        logic [15:0] seq;
        logic        last;
        int          gap;
    } hdr_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    hdr_t  hdr_q[$];
    beat_t beat_q[$];

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] model_seq = '0;
    logic stall_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_burst(input logic [7:0] dest, input int blen, input logic [1:0] mode,
                              input int mtu, input int ipg);
        int rem;
        int m;
        int len;
        bit first;
        hdr_t h;
        beat_t b;
        logic [7:0] byte_v;
        rem = blen;
        m = (mtu == 0) ? 1 : mtu;
        first = 1'b1;
        while (rem > 0) begin
            len = (rem < m) ? rem : m;
            h.dest = dest;
            h.len  = 16'(len);
            h.seq  = model_seq;
            h.last = (len == rem);
            h.gap  = first ? -1 : ipg + 1;
            hdr_q.push_back(h);
            for (int off = 0; off < len; off += 8) begin
                b.data = '0;
                b.keep = '0;
                b.last = (off + 8 >= len);
                for (int i = 0; i < 8; i++) begin
                    if (off + i < len) begin
                        b.keep[i] = 1'b1;
                        case (mode)
                            2'd0:    byte_v = 8'((off + i) % 256);
                            2'd1:    byte_v = 8'h00;
                            2'd2:    byte_v = model_seq[7:0];
                            default: byte_v = 8'hFF;
                        endcase
                        b.data[i*8 +: 8] = byte_v;
                    end
                end
                beat_q.push_back(b);
            end
            rem -= len;
            model_seq++;
            first = 1'b0;
        end
    endtask

    // Drives one descriptor, then scrambles the side inputs to prove they were latched.
    task automatic send_bd(input logic [7:0] dest, input int blen, input logic [1:0] mode,
                           input int mtu, input int ipg);
        int waited;
        @(posedge clk); #1;
        input_bd_valid     = 1'b1;
        input_bd_dest      = dest;
        input_bd_burst_len = 32'(blen);
        input_bd_mode      = mode;
        payload_mtu        = 16'(mtu);
        ipg_cycles         = 8'(ipg);
        push_burst(dest, blen, mode, mtu, ipg);
        waited = 0;
        while (1) begin
            @(negedge clk);
            if (input_bd_ready) break;
            waited++;
            if (waited > 5000) begin
                check("bd_ready_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk); #1;
        input_bd_valid     = 1'b0;
        input_bd_dest      = 8'($urandom);
        input_bd_burst_len = 32'($urandom_range(1, 50));
        input_bd_mode      = 2'($urandom);
        payload_mtu        = 16'($urandom_range(1, 7));
        ipg_cycles         = 8'($urandom_range(5, 9));
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((hdr_q.size() != 0 || beat_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("drain_timeout", 1, 0);
    endtask

    // Ready randomiser; updates just after the edge so negedge samples see settled values.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (stall_en) begin
                output_payload_tready = ($urandom_range(0, 3) != 0);
                output_hdr_ready      = ($urandom_range(0, 2) != 0);
            end else begin
                output_payload_tready = 1'b1;
                output_hdr_ready      = 1'b1;
            end
        end
    end

    int          cyc = 0;
    int          last_acc_cyc = 0;
    logic        gap_pending = 1'b0;
    logic        prev_hv = 1'b0;
    logic        prev_tstall = 1'b0;
    logic        prev_hstall = 1'b0;
    logic [63:0] prev_tdata;
    logic [7:0]  prev_tkeep;
    logic        prev_tlast;
    logic [15:0] prev_hlen;
    logic [15:0] prev_hseq;

    always @(negedge clk) begin
        hdr_t  h;
        beat_t b;
        cyc++;
        if (rst) begin
            gap_pending = 1'b0;
            prev_hv     = 1'b0;
            prev_tstall = 1'b0;
            prev_hstall = 1'b0;
        end else begin
            if (prev_tstall) begin
                check("tdata_stall", output_payload_tdata, prev_tdata);
                check("tkeep_stall", output_payload_tkeep, prev_tkeep);
                check("tlast_stall", output_payload_tlast, prev_tlast);
            end
            if (prev_hstall) begin
                check("hdr_len_stall", output_hdr_len, prev_hlen);
                check("hdr_seq_stall", output_hdr_seq, prev_hseq);
            end
            if (gap_pending && !output_hdr_valid) check("busy_gap", busy, 1);
            if (output_hdr_valid && !prev_hv && hdr_q.size() != 0 && hdr_q[0].gap >= 0)
                check("ipg_gap", cyc - last_acc_cyc, hdr_q[0].gap);
            if (output_hdr_valid) gap_pending = 1'b0;
            if (output_hdr_valid && output_hdr_ready) begin
                if (hdr_q.size() == 0) begin
                    check("hdr_unexpected", 1, 0);
                end else begin
                    h = hdr_q.pop_front();
                    check("hdr_dest", output_hdr_dest, h.dest);
                    check("hdr_len", output_hdr_len, h.len);
                    check("hdr_seq", output_hdr_seq, h.seq);
                    check("hdr_last", output_hdr_last, h.last);
                end
            end
            if (output_payload_tvalid && output_payload_tready) begin
                if (beat_q.size() == 0) begin
                    check("beat_unexpected", 1, 0);
                end else begin
                    b = beat_q.pop_front();
                    check("tdata", output_payload_tdata, b.data);
                    check("tkeep", output_payload_tkeep, b.keep);
                    check("tlast", output_payload_tlast, b.last);
                    check("tuser", output_payload_tuser, 0);
                    if (output_payload_tlast) begin
                        last_acc_cyc = cyc;
                        gap_pending = (hdr_q.size() != 0) && (hdr_q[0].gap >= 0);
                    end
                end
            end
            if (output_payload_tvalid && output_hdr_valid) check("hdr_and_tvalid", 1, 0);
            prev_hv     = output_hdr_valid;
            prev_tstall = output_payload_tvalid && !output_payload_tready;
            prev_hstall = output_hdr_valid && !output_hdr_ready;
            prev_tdata  = output_payload_tdata;
            prev_tkeep  = output_payload_tkeep;
            prev_tlast  = output_payload_tlast;
            prev_hlen   = output_hdr_len;
            prev_hseq   = output_hdr_seq;
        end
    end

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_bd_ready"}, input_bd_ready, 0);
        check({pfx, "_hdr_valid"}, output_hdr_valid, 0);
        check({pfx, "_tvalid"}, output_payload_tvalid, 0);
        check({pfx, "_tlast"}, output_payload_tlast, 0);
        check({pfx, "_tkeep"}, output_payload_tkeep, 0);
        check({pfx, "_tdata"}, output_payload_tdata, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_seq"}, output_hdr_seq, 0);
    endtask

    initial begin
        int n;
        #12;
        check_reset_outputs("rst0");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("bd_ready_after_rst", input_bd_ready, 1);

        // 20 bytes over MTU 8, incrementing pattern, back-to-back packets
        send_bd(8'h5A, 20, 2'd0, 8, 0);
        drain(500);

        // Zero-length burst produces nothing and stays idle
        send_bd(8'h11, 0, 2'd1, 8, 0);
        check("zero_len_ready", input_bd_ready, 1);
        check("zero_len_busy", busy, 0);
        repeat (6) begin
            @(negedge clk);
            check("zero_len_busy_hold", busy, 0);
        end

        // MTU 0 behaves as 1
        send_bd(8'h22, 3, 2'd3, 0, 0);
        drain(500);

        // Random backpressure on both outputs
        stall_en = 1'b1;
        send_bd(8'h33, 1000, 2'd0, 256, 0);
        drain(5000);
        stall_en = 1'b0;

        // Inter-packet gap with sequence-number fill
        send_bd(8'h44, 20, 2'd2, 8, 3);
        drain(500);

        // Odd length with all-zero fill and a gap of one
        send_bd(8'h55, 13, 2'd1, 6, 1);
        drain(500);

        // Reset mid-payload
        send_bd(8'h66, 100, 2'd0, 64, 0);
        n = 0;
        while (!output_payload_tvalid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("tvalid_timeout", 1, 0);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        hdr_q.delete();
        beat_q.delete();
        model_seq = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("bd_ready_after_rst2", input_bd_ready, 1);
        repeat (3) @(negedge clk);
        check("no_resume_busy", busy, 0);
        send_bd(8'h77, 10, 2'd2, 8, 0);
        drain(500);

        check("hdr_q_empty", hdr_q.size(), 0);
        check("beat_q_empty", beat_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
